// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the picorv32 native-interface bus fabric.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEADBEEF;
    localparam int          MEM_ADDR_W    = 32;
    localparam int          MEM_STRB_W    = 4;
    localparam int          MAX_SLAVES    = 16;

endpackage

// File: rtl/mem_bus_decoder.sv
// Combinational address match with lowest-index priority: one-hot hit, binary sel, no-match flag.
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter int                       N_SLAVES   = 5,
    parameter int                       SEL_W      = 3,
    parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0]   SLAVE_MASK = {N_SLAVES{32'hFF000000}}
) (
    input  logic [MEM_ADDR_W-1:0] addr,
    output logic [N_SLAVES-1:0]   hit,
    output logic [SEL_W-1:0]      sel,
    output logic                  no_match
);

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit      = '0;
        sel      = '0;
        no_match = 1'b1;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit      = '0;
                hit[i]   = 1'b1;
                sel      = SEL_W'(i);
                no_match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master, N-slave fabric for the picorv32 native memory interface.
// Optional slave-stall abort is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_fabric
    import mem_bus_pkg::*;
#(
    parameter int                       N_SLAVES       = 5,
    parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE     = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0]   SLAVE_MASK     = {N_SLAVES{32'hFF000000}},
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid_i,
    input  logic [MEM_ADDR_W-1:0]    mem_addr_i,
    input  logic [31:0]              mem_wdata_i,
    input  logic [MEM_STRB_W-1:0]    mem_wstrb_i,
    output logic                     mem_ready_o,
    output logic [31:0]              mem_rdata_o,
    output logic [N_SLAVES-1:0]      s_valid_o,
    output logic [MEM_ADDR_W-1:0]    s_addr_o,
    output logic [31:0]              s_wdata_o,
    output logic [MEM_STRB_W-1:0]    s_wstrb_o,
    input  logic [N_SLAVES-1:0]      s_ready_i,
    input  logic [N_SLAVES*32-1:0]   s_rdata_i,
    output logic                     bus_err_o
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    if (N_SLAVES < 1 || N_SLAVES > MAX_SLAVES || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_param_check
        $error("mem_bus_fabric: N_SLAVES or TIMEOUT_CYCLES out of range");
    end

    logic [N_SLAVES-1:0] hit;
    logic [SEL_W-1:0]    sel;
    logic [SEL_W-1:0]    sel_q;
    logic                no_match;
    bus_state_t          state;
`ifdef MEM_BUS_TIMEOUT_EN
    logic [15:0]         timeout_cnt;
`endif

    mem_bus_decoder #(
        .N_SLAVES   (N_SLAVES),
        .SEL_W      (SEL_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .addr     (mem_addr_i),
        .hit      (hit),
        .sel      (sel),
        .no_match (no_match)
    );

    // Only the slave latched at decode time may complete the access; writes always answer 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel_q       <= '0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            s_valid_o   <= '0;
            s_addr_o    <= '0;
            s_wdata_o   <= '0;
            s_wstrb_o   <= '0;
            bus_err_o   <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid_i) begin
                        s_addr_o  <= mem_addr_i;
                        s_wdata_o <= mem_wdata_i;
                        s_wstrb_o <= mem_wstrb_i;
                        if (no_match) begin
                            state       <= RESP;
                            mem_ready_o <= 1'b1;
                            mem_rdata_o <= '0;
                            bus_err_o   <= 1'b1;
                        end else begin
                            state     <= ACTIVE;
                            s_valid_o <= hit;
                            sel_q     <= sel;
`ifdef MEM_BUS_TIMEOUT_EN
                            timeout_cnt <= '0;
`endif
                        end
                    end
                end
                ACTIVE: begin
                    if (s_ready_i[sel_q]) begin
                        state       <= RESP;
                        s_valid_o   <= '0;
                        mem_ready_o <= 1'b1;
                        mem_rdata_o <= (s_wstrb_o == '0) ? s_rdata_i[32*sel_q +: 32] : '0;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (timeout_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        state       <= RESP;
                        s_valid_o   <= '0;
                        mem_ready_o <= 1'b1;
                        mem_rdata_o <= BUS_ERR_RDATA;
                        bus_err_o   <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    state       <= IDLE;
                    mem_ready_o <= 1'b0;
                    mem_rdata_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed scoreboard bench for mem_bus_fabric; main instance plus an overlapping-base instance.
module tb_mem_bus_fabric;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            mem_valid;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic [N-1:0]    s_valid;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [N-1:0]    s_ready;
    logic [N*32-1:0] s_rdata;
    logic            bus_err;

    logic            ov_valid;
    logic            ov_ready;
    logic [31:0]     ov_rdata;
    logic [N-1:0]    ov_s_valid;
    logic [31:0]     ov_s_addr;
    logic [31:0]     ov_s_wdata;
    logic [3:0]      ov_s_wstrb;
    logic [N-1:0]    ov_s_ready;
    logic [N*32-1:0] ov_s_rdata;
    logic            ov_err;

    int              tests = 0;
    int              failures = 0;
    logic [31:0]     expQ[$];
    logic [31:0]     expVal;

    always #5 clk = ~clk;

    mem_bus_fabric #(
        .N_SLAVES       (N),
        .SLAVE_BASE     ({32'h01000000, 32'h00100000, 32'h00000000}),
        .SLAVE_MASK     ({3{32'hFFF00000}}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk), .reset (reset),
        .mem_valid_i (mem_valid), .mem_addr_i (mem_addr), .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb), .mem_ready_o (mem_ready), .mem_rdata_o (mem_rdata),
        .s_valid_o (s_valid), .s_addr_o (s_addr), .s_wdata_o (s_wdata), .s_wstrb_o (s_wstrb),
        .s_ready_i (s_ready), .s_rdata_i (s_rdata), .bus_err_o (bus_err)
    );

    mem_bus_fabric #(
        .N_SLAVES       (N),
        .SLAVE_BASE     ({32'h00000000, 32'h00100000, 32'h00000000}),
        .SLAVE_MASK     ({3{32'hFFF00000}}),
        .TIMEOUT_CYCLES (8)
    ) dut_ov (
        .clk (clk), .reset (reset),
        .mem_valid_i (ov_valid), .mem_addr_i (mem_addr), .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb), .mem_ready_o (ov_ready), .mem_rdata_o (ov_rdata),
        .s_valid_o (ov_s_valid), .s_addr_o (ov_s_addr), .s_wdata_o (ov_s_wdata), .s_wstrb_o (ov_s_wstrb),
        .s_ready_i (ov_s_ready), .s_rdata_i (ov_s_rdata), .bus_err_o (ov_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // slave < 0 means an unmapped address; the slave answers rdata_in after delay cycles of s_valid.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input int slave, input int delay, input logic [31:0] rdata_in,
                                 input logic [31:0] exp_rdata);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        expQ.push_back(exp_rdata);
        @(negedge clk);
        if (slave >= 0) begin
            checkOutput("s_valid_decode", 32'(s_valid), 32'(1) << slave);
            checkOutput("s_addr", s_addr, addr);
            checkOutput("s_wdata", s_wdata, wdata);
            checkOutput("s_wstrb", 32'(s_wstrb), 32'(wstrb));
            checkOutput("ready_early", 32'(mem_ready), 32'd0);
            repeat (delay) @(negedge clk);
            checkOutput("s_valid_hold", 32'(s_valid), 32'(1) << slave);
            s_ready[slave]           = 1'b1;
            s_rdata[32*slave +: 32]  = rdata_in;
            @(negedge clk);
            s_ready = '0;
            s_rdata = '0;
        end
        checkOutput("mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("s_valid_clear", 32'(s_valid), 32'd0);
        expVal = expQ.pop_front();
        if (mem_ready) checkOutput("mem_rdata", mem_rdata, expVal);
        @(negedge clk);
        mem_valid = 1'b0;
        checkOutput("ready_pulse", 32'(mem_ready), 32'd0);
        checkOutput("rdata_idle", mem_rdata, 32'd0);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        mem_valid  = 1'b0;
        ov_valid   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        s_ready    = '0;
        s_rdata    = '0;
        ov_s_ready = '0;
        ov_s_rdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(mem_ready), 32'd0);
        checkOutput("reset_svalid", 32'(s_valid), 32'd0);
        checkOutput("reset_err", 32'(bus_err), 32'd0);
        reset = 1'b0;

        applyStimulus(32'h00100004, 32'h0, 4'h0, 1, 2, 32'h12345678, 32'h12345678);
        applyStimulus(32'h01000008, 32'hA5A5A5A5, 4'hF, 2, 1, 32'hFFFFFFFF, 32'h0);
        applyStimulus(32'h00000040, 32'h0, 4'h0, 0, 0, 32'hCAFE0001, 32'hCAFE0001);
        checkOutput("err_before_unmapped", 32'(bus_err), 32'd0);
        applyStimulus(32'h20000000, 32'h0, 4'h0, -1, 0, 32'h0, 32'h0);
        checkOutput("err_set", 32'(bus_err), 32'd1);
        applyStimulus(32'h00100010, 32'h0, 4'h0, 1, 0, 32'h0000BEEF, 32'h0000BEEF);
        checkOutput("err_sticky", 32'(bus_err), 32'd1);
        checkOutput("s_addr_hold", s_addr, 32'h00100010);

        // Reset mid-access abandons the transaction.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h00000080;
        mem_wstrb = 4'h0;
        @(negedge clk);
        checkOutput("pre_reset_svalid", 32'(s_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        mem_valid = 1'b0;
        checkOutput("rst_active_svalid", 32'(s_valid), 32'd0);
        checkOutput("rst_active_ready", 32'(mem_ready), 32'd0);
        checkOutput("rst_active_err", 32'(bus_err), 32'd0);
        checkOutput("rst_active_saddr", s_addr, 32'd0);
        s_ready = 3'b001;
        @(negedge clk);
        s_ready = '0;
        checkOutput("rst_no_response", 32'(mem_ready), 32'd0);
        applyStimulus(32'h00000084, 32'h0, 4'h0, 0, 1, 32'h600DF00D, 32'h600DF00D);

        // Overlapping bases: slave 0 wins, slave 2 ready is ignored.
        @(negedge clk);
        ov_valid = 1'b1;
        mem_addr = 32'h00000010;
        expQ.push_back(32'h0BADF00D);
        @(negedge clk);
        checkOutput("ov_sel", 32'(ov_s_valid), 32'd1);
        ov_s_ready = 3'b100;
        ov_s_rdata = {32'h11111111, 32'h0, 32'h0};
        @(negedge clk);
        ov_s_ready = '0;
        checkOutput("ov_ignore_ready", 32'(ov_ready), 32'd0);
        checkOutput("ov_still_valid", 32'(ov_s_valid), 32'd1);
        ov_s_ready = 3'b001;
        ov_s_rdata = {32'h11111111, 32'h0, 32'h0BADF00D};
        @(negedge clk);
        ov_s_ready = '0;
        checkOutput("ov_ready", 32'(ov_ready), 32'd1);
        expVal = expQ.pop_front();
        checkOutput("ov_rdata", ov_rdata, expVal);
        @(negedge clk);
        ov_valid = 1'b0;

        // Slave 1 never answers.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h00100020;
        mem_wstrb = 4'h0;
`ifdef MEM_BUS_TIMEOUT_EN
        expQ.push_back(32'hDEADBEEF);
        n = 0;
        while (n < 20 && !mem_ready) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_latency", 32'(n), 32'd9);
        expVal = expQ.pop_front();
        checkOutput("timeout_rdata", mem_rdata, expVal);
        checkOutput("timeout_err", 32'(bus_err), 32'd1);
        s_ready = 3'b010;
        s_rdata = {32'h0, 32'h77777777, 32'h0};
        @(negedge clk);
        mem_valid = 1'b0;
        s_ready   = '0;
        @(negedge clk);
        checkOutput("late_ready_ignored", 32'(mem_ready), 32'd0);
`else
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ready) n++;
        end
        checkOutput("no_timeout_ready", 32'(n), 32'd0);
        checkOutput("no_timeout_svalid", 32'(s_valid), 32'd2);
        checkOutput("no_timeout_err", 32'(bus_err), 32'd0);
        mem_valid = 1'b0;
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("final_reset_svalid", 32'(s_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
